wb_seq_mult_slave: RTL and testbench
====================================

// Module: wb_seq_mult_slave
// PURPOSE
//   Wishbone responder that exposes the sequential shift-add multiplier to the management SoC.
//   The SoC writes operands, starts a multiply, polls status or takes an IRQ, then reads the product.
//   Sits in user_project_wrapper on the wbs_* slave port, in place of the pad-driven operand path.
// PARAMETERS
//   WIDTH      16            operand width; product is 2*WIDTH (legal 2..32)
//   BASE_ADDR  32'h3000_0000 base of the register window
//   ADDR_MASK  32'hFFFF_FFE0 address bits compared against BASE_ADDR (32-byte window)
// PORTS
//   wb_clk_i     in   1      single clock
//   wb_rst_ni    in   1      asynchronous reset, active-low
//   wbs_cyc_i    in   1      bus cycle
//   wbs_stb_i    in   1      strobe
//   wbs_we_i     in   1      1 = write
//   wbs_sel_i    in   4      byte enables (honoured on writes)
//   wbs_adr_i    in   32     byte address
//   wbs_dat_i    in   32     write data
//   wbs_ack_o    out  1      acknowledge
//   wbs_dat_o    out  32     read data
//   user_irq     out  1      done interrupt (level)
// BEHAVIOUR
//   Reset: wbs_ack_o=0, wbs_dat_o=0, user_irq=0; all registers 0; core IDLE.
//   Bus: selected = cyc&stb&((adr&ADDR_MASK)==BASE_ADDR). ack is registered: high exactly one
//     cycle after selected, then low for one cycle (no back-to-back ack). Write takes effect at the ack edge.
//     Read data is valid in the ack cycle and 0 otherwise. Unmapped offset: ack, read 0, write ignored.
//   Register map (offset):
//     0x00 CTRL    [0] START (W1, reads 0)  [1] IRQ_EN  [2] SIGNED (see CONFIGURATION)
//     0x04 OP_A    [WIDTH-1:0] RW, byte-masked by sel
//     0x08 OP_B    [WIDTH-1:0] RW, byte-masked by sel
//     0x0C STATUS  [0] BUSY (RO)  [1] DONE (sticky, W1C)  [2] OVERRUN (sticky, W1C)
//     0x10 RES_LO  product[31:0] RO   0x14 RES_HI  product[2W-1:32] RO, 0 when WIDTH<=16
//   Core FSM: IDLE -> RUN on START; RUN lasts exactly WIDTH cycles (one multiplier bit per cycle, LSB first,
//     acc += mcand<<i); RUN -> FINISH (1 cycle: load result, set DONE, clear BUSY) -> IDLE.
//   Latency: START write ack edge to DONE=1 = WIDTH+1 cycles. BUSY=1 from the edge after START through RUN.
//   Operands are latched at START; OP_A/OP_B writes during RUN are accepted and affect only the next run.
//   START while BUSY: ignored, OVERRUN set, running product is unaffected.
//   START in the same cycle as DONE W1C: the clear applies to the old DONE; the new run sets it again later.
//   Set of DONE in the same cycle as a W1C write to it: the set wins.
//   RES_* hold the last completed product until the next FINISH; they never show partial sums.
//   user_irq = DONE & IRQ_EN, registered; it drops the cycle after a DONE clear or an IRQ_EN clear.
//   Async reset mid-run: everything returns to reset values immediately, no ack is issued.
//   Zero operand: the run still takes the full WIDTH cycles (no early exit).
// CONFIGURATION
//   SEQ_MULT_SIGNED_EN defined: CTRL[2] is RW and selects two's-complement mode.
//     Operands are sign-extended and the final partial product is subtracted (MSB weight negative).
//     Latency is unchanged.
//   Not defined: CTRL[2] reads 0 and ignores writes; unsigned only; the subtract path is not built.
// STRUCTURE
//   seq_mult_pkg: register offsets, CTRL/STATUS bit indices, FSM state enum {IDLE,RUN,FINISH}.
//   Sub-module seq_mult_core (start, a, b, signed_mode -> busy, done pulse, product) holds the FSM/datapath.
//   This module holds the bus decode, registers, ack and irq logic.
// TESTING (WIDTH=16)
//   Write OP_A=0xFFFF, OP_B=0xFFFF, CTRL=1 -> BUSY for 16 cycles; DONE after 17; RES_LO=0xFFFE0001, RES_HI=0.
//   Write OP_A=0x1234 with sel=4'b0001 over 0xABCD -> OP_A reads 0xAB34.
//   START, then START again 3 cycles later -> OVERRUN=1; product of the first operands is unchanged.
//   CTRL=0x3, multiply 3*5 -> user_irq=1 and RES_LO=15; write STATUS=0x2 -> DONE=0 and irq low the next cycle.
//   Assert wb_rst_ni at RUN cycle 8 -> BUSY=0, RES_LO=0, ack=0; a new run then completes correctly.
//   With SEQ_MULT_SIGNED_EN: CTRL=0x5, OP_A=0xFFFE, OP_B=0x0003 -> RES_LO=0xFFFFFFFA; without it, 0x0002FFFA.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the Wishbone sequential multiplier: register word
// indices, CTRL/STATUS bit positions and the core FSM state type.
// Optional feature macro: SEQ_MULT_SIGNED_EN (two's-complement mode).
package seq_mult_pkg;

  // Register word indices (byte offset >> 2) inside the 32-byte window
  localparam logic [2:0] REG_CTRL   = 3'd0;  // 0x00
  localparam logic [2:0] REG_OP_A   = 3'd1;  // 0x04
  localparam logic [2:0] REG_OP_B   = 3'd2;  // 0x08
  localparam logic [2:0] REG_STATUS = 3'd3;  // 0x0C
  localparam logic [2:0] REG_RES_LO = 3'd4;  // 0x10
  localparam logic [2:0] REG_RES_HI = 3'd5;  // 0x14

  // CTRL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_SIGNED = 2;

  // STATUS bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Word index of a byte offset; byte lanes within a word are not decoded
  function automatic logic [2:0] reg_index(input logic [4:0] byte_off);
    return byte_off[4:2];
  endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Sequential shift-add multiplier: one multiplier bit per RUN cycle, LSB
// first, followed by a single FINISH cycle that publishes the product.
// Optional feature macro: SEQ_MULT_SIGNED_EN (sign-extended multiplicand,
// final partial product subtracted).
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  state_e           state_reg, state_next;
  logic [PW-1:0]    acc_reg, acc_next;
  logic [PW-1:0]    mcand_reg, mcand_next;
  logic [PW-1:0]    product_reg, product_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    step_sum;
  logic             load;

  assign partial = mplier_reg[0] ? mcand_reg : '0;

`ifdef SEQ_MULT_SIGNED_EN
  logic mode_reg, mode_next;

  // The MSB of a two's-complement multiplier carries negative weight
  assign a_ext    = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign step_sum = (mode_reg && (cnt_reg == CW'(WIDTH - 1))) ? (acc_reg - partial)
                                                              : (acc_reg + partial);

  // Mode is captured with the operands so a CTRL write mid-run has no effect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_reg <= 1'b0;
    else        mode_reg <= mode_next;
  end
`else
  logic unused_signed_mode;

  assign unused_signed_mode = signed_mode;
  assign a_ext              = {{WIDTH{1'b0}}, a};
  assign step_sum           = acc_reg + partial;
`endif

  // Next-state, datapath update and status outputs
  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    busy         = 1'b0;
    done         = 1'b0;
    load         = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    mode_next    = mode_reg;
`endif
    case (state_reg)
      IDLE: begin
        load = start;
      end
      RUN: begin
        busy        = 1'b1;
        acc_next    = step_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) state_next = FINISH;
      end
      FINISH: begin
        done         = 1'b1;
        product_next = acc_reg;
        state_next   = IDLE;
        // A start arriving on the publish cycle begins the next run directly
        load         = start;
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      state_next  = RUN;
      acc_next    = '0;
      mcand_next  = a_ext;
      mplier_next = b;
      cnt_next    = '0;
`ifdef SEQ_MULT_SIGNED_EN
      mode_next   = signed_mode;
`endif
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  assign product = product_reg;

endmodule

// File: rtl/wb_seq_mult_slave.sv
// Wishbone register front-end for seq_mult_core: address decode, operand and
// control registers, sticky DONE/OVERRUN status, registered ack and level IRQ.
// Optional feature macro: SEQ_MULT_SIGNED_EN (CTRL[2] selects signed mode).
module wb_seq_mult_slave
  import seq_mult_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFE0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        user_irq
);

  localparam int PW = 2 * WIDTH;

  logic             selected, access, wr_en, rd_en;
  logic [2:0]       reg_idx;
  logic [31:0]      byte_mask;
  logic [WIDTH-1:0] merged_a, merged_b;
  logic             wr_ctrl, wr_status, wr_op_a, wr_op_b;
  logic             start_req, done_clr, ovr_clr;
  logic             signed_mode;
  logic [31:0]      rd_data;
  logic [63:0]      product_wide;

  logic             ack_reg, irq_reg, irq_next;
  logic [31:0]      dat_reg, dat_next;
  logic [WIDTH-1:0] op_a_reg, op_a_next, op_b_reg, op_b_next;
  logic             irq_en_reg, irq_en_next;
  logic             done_reg, done_next, overrun_reg, overrun_next;

  logic             core_busy, core_done;
  logic [PW-1:0]    core_product;

  // A transfer is accepted only when no ack went out on the previous edge
  assign selected = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign access   = selected & ~ack_reg;
  assign wr_en    = access & wbs_we_i;
  assign rd_en    = access & ~wbs_we_i;
  assign reg_idx  = reg_index(wbs_adr_i[4:0]);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_mask
      assign byte_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  assign merged_a = WIDTH'((32'(op_a_reg) & ~byte_mask) | (wbs_dat_i & byte_mask));
  assign merged_b = WIDTH'((32'(op_b_reg) & ~byte_mask) | (wbs_dat_i & byte_mask));

  // CTRL and STATUS fields all live in byte lane 0
  assign wr_ctrl   = wr_en & (reg_idx == REG_CTRL) & wbs_sel_i[0];
  assign wr_status = wr_en & (reg_idx == REG_STATUS) & wbs_sel_i[0];
  assign wr_op_a   = wr_en & (reg_idx == REG_OP_A);
  assign wr_op_b   = wr_en & (reg_idx == REG_OP_B);
  assign start_req = wr_ctrl & wbs_dat_i[CTRL_START];
  assign done_clr  = wr_status & wbs_dat_i[STAT_DONE];
  assign ovr_clr   = wr_status & wbs_dat_i[STAT_OVERRUN];

`ifdef SEQ_MULT_SIGNED_EN
  logic signed_reg;

  // Signed-mode select, plain RW bit
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)   signed_reg <= 1'b0;
    else if (wr_ctrl) signed_reg <= wbs_dat_i[CTRL_SIGNED];
  end

  assign signed_mode = signed_reg;
`else
  assign signed_mode = 1'b0;
`endif

  assign product_wide = 64'(core_product);

  // Read mux for the addressed register; unmapped words read as zero
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_CTRL: begin
        rd_data[CTRL_IRQ_EN] = irq_en_reg;
        rd_data[CTRL_SIGNED] = signed_mode;
      end
      REG_OP_A:   rd_data = 32'(op_a_reg);
      REG_OP_B:   rd_data = 32'(op_b_reg);
      REG_STATUS: begin
        rd_data[STAT_BUSY]    = core_busy;
        rd_data[STAT_DONE]    = done_reg;
        rd_data[STAT_OVERRUN] = overrun_reg;
      end
      REG_RES_LO: rd_data = product_wide[31:0];
      REG_RES_HI: rd_data = product_wide[63:32];
      default:    rd_data = '0;
    endcase
  end

  // Register next values; a completion pulse beats a simultaneous DONE clear
  always_comb begin
    dat_next     = rd_en ? rd_data : '0;
    op_a_next    = wr_op_a ? merged_a : op_a_reg;
    op_b_next    = wr_op_b ? merged_b : op_b_reg;
    irq_en_next  = wr_ctrl ? wbs_dat_i[CTRL_IRQ_EN] : irq_en_reg;
    done_next    = (done_reg & ~done_clr) | core_done;
    overrun_next = (overrun_reg & ~ovr_clr) | (start_req & core_busy);
    irq_next     = done_reg & irq_en_reg;
  end

  // Bus-side registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_reg     <= 1'b0;
      dat_reg     <= '0;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      irq_en_reg  <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      ack_reg     <= access;
      dat_reg     <= dat_next;
      op_a_reg    <= op_a_next;
      op_b_reg    <= op_b_next;
      irq_en_reg  <= irq_en_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
      irq_reg     <= irq_next;
    end
  end

  seq_mult_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_ni),
    .start       (start_req),
    .a           (op_a_reg),
    .b           (op_b_reg),
    .signed_mode (signed_mode),
    .busy        (core_busy),
    .done        (core_done),
    .product     (core_product)
  );

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign user_irq  = irq_reg;

endmodule

// File: tb/tb_wb_seq_mult_slave.sv
// Self-checking bench for wb_seq_mult_slave (WIDTH=16) against a plain
// arithmetic product model. Honours SEQ_MULT_SIGNED_EN when defined.
`timescale 1ns/1ps
module tb_wb_seq_mult_slave;

  localparam int          WIDTH = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] O_CTRL = 32'h00, O_OPA = 32'h04, O_OPB = 32'h08;
  localparam logic [31:0] O_STAT = 32'h0C, O_RLO = 32'h10, O_RHI = 32'h14;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        ack, irq;
  logic [31:0] dat_r;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int last_ack = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  wb_seq_mult_slave #(.WIDTH(WIDTH), .BASE_ADDR(BASE), .ADDR_MASK(32'hFFFF_FFE0)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack),
    .wbs_dat_o(dat_r), .user_irq(irq));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference: product of the operands as integers, low 32 bits (2*WIDTH = 32)
  function automatic logic [31:0] ref_lo(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    longint pa, pb;
    if (sgn) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({48'h0, a});
      pb = longint'({48'h0, b});
    end
    return 32'(pa * pb);
  endfunction

  // One Wishbone transfer; expects an ack within 8 edges
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rdata, output int ack_cyc);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    n = 0; ack_cyc = -1; rdata = '0;
    while (n < 8) begin
      @(posedge clk); #1; n++;
      if (ack) begin ack_cyc = cycle; rdata = dat_r; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("[TB] %s adr=%h dat=%h sel=%h ack_cycle=%0d", w ? "wr" : "rd", a, w ? d : rdata, s, ack_cyc);
    if (ack_cyc < 0) begin
      tests++; fails++;
      $display("FAIL bus_ack adr=%h got no ack want ack within 8 cycles", a);
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] junk;
    bus(1'b1, BASE + off, d, s, junk, last_ack);
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    bus(1'b0, BASE + off, 32'h0, 4'hF, d, last_ack);
  endtask

  task automatic wait_until(input int t);
    while (cycle < t) begin @(posedge clk); #1; end
  endtask

  // Poll STATUS until DONE; returns 1 if it came up within the budget
  task automatic wait_done(output logic ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rd(O_STAT, s);
      if (s[1]) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL wait_done got DONE=0 want DONE=1 within 30 polls"); end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (ack !== 1'b0)  begin fails++; $display("FAIL reset_ack got %b want 0", ack); end
    tests++; if (dat_r !== '0)  begin fails++; $display("FAIL reset_dat got %h want 0", dat_r); end
    tests++; if (irq !== 1'b0)  begin fails++; $display("FAIL reset_irq got %b want 0", irq); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 6; r++) begin
      rd(32'(r * 4), v);
      tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_reg%0d got %h want 0", r, v); end
    end
  endtask

  task automatic test_basic_timing();
    logic [31:0] v;
    int c0;
    wr(O_OPA, 32'hFFFF, 4'hF);
    wr(O_OPB, 32'hFFFF, 4'hF);
    wr(O_CTRL, 32'h1, 4'hF);
    c0 = last_ack;
    wait_until(c0 + 15);
    rd(O_STAT, v);
    tests++; if (last_ack !== c0 + 16) begin fails++; $display("FAIL basic_ack16 got %0d want %0d", last_ack, c0 + 16); end
    tests++; if (v !== 32'h1) begin fails++; $display("FAIL basic_status_run16 got %h want 1", v); end
    wait_until(c0 + 17);
    rd(O_STAT, v);
    tests++; if (v !== 32'h2) begin fails++; $display("FAIL basic_status_done18 got %h want 2", v); end
    rd(O_RLO, v);
    tests++; if (v !== 32'hFFFE0001) begin fails++; $display("FAIL basic_res_lo got %h want fffe0001", v); end
    rd(O_RHI, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL basic_res_hi got %h want 0", v); end
    wr(O_STAT, 32'h2, 4'hF);
  endtask

  task automatic test_byte_mask();
    logic [31:0] v;
    wr(O_OPA, 32'hABCD, 4'hF);
    wr(O_OPA, 32'h1234, 4'b0001);
    rd(O_OPA, v);
    tests++; if (v !== 32'hAB34) begin fails++; $display("FAIL mask_op_a got %h want ab34", v); end
    wr(O_OPB, 32'hFFFF_FFFF, 4'hF);
    wr(O_OPB, 32'h5A00_0000, 4'b1000);
    rd(O_OPB, v);
    tests++; if (v !== 32'hFFFF) begin fails++; $display("FAIL mask_op_b got %h want ffff", v); end
    wr(O_OPB, 32'h0000_7700, 4'b0010);
    rd(O_OPB, v);
    tests++; if (v !== 32'h77FF) begin fails++; $display("FAIL mask_op_b_lane1 got %h want 77ff", v); end
  endtask

  task automatic test_ack_pattern();
    logic [5:0] seen;
    logic       dat_bad;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + O_OPA; sel = 4'hF;
    seen = '0; dat_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen[5 - i] = ack;
      if (!ack && dat_r !== 32'h0) dat_bad = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    $display("[TB] rd-hold adr=%h ack_pattern=%b", BASE + O_OPA, seen);
    tests++; if (seen !== 6'b101010) begin fails++; $display("FAIL ack_pattern got %b want 101010", seen); end
    tests++; if (dat_bad) begin fails++; $display("FAIL dat_idle_zero got nonzero want 0 outside ack"); end
  endtask

  task automatic test_unmapped();
    logic [31:0] v;
    logic        any_ack;
    wr(32'h18, 32'hFFFF_FFFF, 4'hF);
    rd(32'h18, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL unmapped_18 got %h want 0", v); end
    rd(32'h1C, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL unmapped_1c got %h want 0", v); end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h20; sel = 4'hF;
    any_ack = 1'b0;
    repeat (4) begin @(posedge clk); #1; any_ack |= ack; end
    cyc = 1'b0; adr = BASE + O_OPA;
    repeat (4) begin @(posedge clk); #1; any_ack |= ack; end
    stb = 1'b0;
    $display("[TB] rd-probe outside window / cyc low, ack_seen=%b", any_ack);
    tests++; if (any_ack !== 1'b0) begin fails++; $display("FAIL no_select_ack got %b want 0", any_ack); end
  endtask

  task automatic test_overrun();
    logic [31:0] v;
    logic        ok;
    int          c0;
    wr(O_OPA, 32'd7, 4'hF);
    wr(O_OPB, 32'd9, 4'hF);
    wr(O_CTRL, 32'h1, 4'hF);
    c0 = last_ack;
    wait_until(c0 + 2);
    wr(O_CTRL, 32'h1, 4'hF);
    wr(O_OPA, 32'd100, 4'hF);
    wr(O_OPB, 32'd9, 4'hF);
    wait_done(ok);
    rd(O_STAT, v);
    tests++; if (v !== 32'h6) begin fails++; $display("FAIL overrun_status got %h want 6", v); end
    rd(O_RLO, v);
    tests++; if (v !== 32'd63) begin fails++; $display("FAIL overrun_product got %0d want 63", v); end
    rd(O_OPA, v);
    tests++; if (v !== 32'd100) begin fails++; $display("FAIL overrun_op_a got %0d want 100", v); end
    wr(O_STAT, 32'h6, 4'hF);
    rd(O_STAT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL overrun_w1c got %h want 0", v); end
    wr(O_CTRL, 32'h1, 4'hF);
    wait_done(ok);
    rd(O_RLO, v);
    tests++; if (v !== 32'd900) begin fails++; $display("FAIL overrun_next_run got %0d want 900", v); end
    wr(O_STAT, 32'h2, 4'hF);
  endtask

  task automatic test_zero_operand();
    logic [31:0] v;
    logic        ok;
    int          c0;
    wr(O_OPA, 32'h0, 4'hF);
    wr(O_OPB, 32'h1234, 4'hF);
    wr(O_CTRL, 32'h1, 4'hF);
    c0 = last_ack;
    wait_until(c0 + 16);
    rd(O_STAT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL zero_finish_status got %h want 0", v); end
    wait_done(ok);
    rd(O_RLO, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL zero_product got %h want 0", v); end
    wr(O_STAT, 32'h2, 4'hF);
  endtask

  task automatic test_irq();
    logic [31:0] v;
    int          c0, n;
    wr(O_OPA, 32'd3, 4'hF);
    wr(O_OPB, 32'd5, 4'hF);
    wr(O_CTRL, 32'h3, 4'hF);
    c0 = last_ack;
    n = 0;
    while (!irq && n < 60) begin @(posedge clk); #1; n++; end
    tests++; if (cycle !== c0 + WIDTH + 2) begin fails++; $display("FAIL irq_latency got %0d want %0d", cycle - c0, WIDTH + 2); end
    rd(O_RLO, v);
    tests++; if (v !== 32'd15) begin fails++; $display("FAIL irq_product got %0d want 15", v); end
    rd(O_CTRL, v);
    tests++; if (v !== 32'h2) begin fails++; $display("FAIL irq_ctrl_read got %h want 2", v); end
    wr(O_STAT, 32'h2, 4'hF);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_hold_at_clear got %b want 1", irq); end
    @(posedge clk); #1;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_drop_done got %b want 0", irq); end
    rd(O_STAT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL irq_status_clear got %h want 0", v); end
    wr(O_CTRL, 32'h3, 4'hF);
    n = 0;
    while (!irq && n < 60) begin @(posedge clk); #1; n++; end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_second got %b want 1", irq); end
    wr(O_CTRL, 32'h0, 4'hF);
    @(posedge clk); #1;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_drop_en got %b want 0", irq); end
    rd(O_STAT, v);
    tests++; if (v !== 32'h2) begin fails++; $display("FAIL irq_done_kept got %h want 2", v); end
    wr(O_STAT, 32'h2, 4'hF);
  endtask

  task automatic test_reset_midrun();
    logic [31:0] v;
    logic        any_ack, ok;
    int          c0;
    wr(O_OPA, 32'h1111, 4'hF);
    wr(O_OPB, 32'h0022, 4'hF);
    wr(O_CTRL, 32'h3, 4'hF);
    c0 = last_ack;
    wait_until(c0 + 8);
    #2;
    rst_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + O_STAT; sel = 4'hF;
    #1;
    tests++; if (dat_r !== 32'h0 || irq !== 1'b0) begin fails++; $display("FAIL midrun_outputs got dat=%h irq=%b want 0 0", dat_r, irq); end
    any_ack = ack;
    repeat (3) begin @(posedge clk); #1; any_ack |= ack; end
    cyc = 1'b0; stb = 1'b0;
    $display("[TB] reset asserted mid-run with read pending, ack_seen=%b", any_ack);
    tests++; if (any_ack !== 1'b0) begin fails++; $display("FAIL midrun_ack got %b want 0", any_ack); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd(O_STAT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL midrun_status got %h want 0", v); end
    rd(O_RLO, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL midrun_res_lo got %h want 0", v); end
    rd(O_CTRL, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL midrun_ctrl got %h want 0", v); end
    wr(O_OPA, 32'h1111, 4'hF);
    wr(O_OPB, 32'h0022, 4'hF);
    wr(O_CTRL, 32'h1, 4'hF);
    wait_done(ok);
    rd(O_RLO, v);
    tests++; if (v !== ref_lo(16'h1111, 16'h0022, 1'b0)) begin fails++; $display("FAIL midrun_rerun got %h want %h", v, ref_lo(16'h1111, 16'h0022, 1'b0)); end
    wr(O_STAT, 32'h2, 4'hF);
  endtask

  task automatic test_signed();
    logic [31:0] v, exp_lo, exp_ctrl;
    logic        ok;
`ifdef SEQ_MULT_SIGNED_EN
    exp_lo = 32'hFFFF_FFFA; exp_ctrl = 32'h4;
`else
    exp_lo = 32'h0002_FFFA; exp_ctrl = 32'h0;
`endif
    wr(O_OPA, 32'hFFFE, 4'hF);
    wr(O_OPB, 32'h0003, 4'hF);
    wr(O_CTRL, 32'h5, 4'hF);
    wait_done(ok);
    rd(O_RLO, v);
    tests++; if (v !== exp_lo) begin fails++; $display("FAIL signed_example got %h want %h", v, exp_lo); end
    rd(O_CTRL, v);
    tests++; if (v !== exp_ctrl) begin fails++; $display("FAIL signed_ctrl_read got %h want %h", v, exp_ctrl); end
    wr(O_STAT, 32'h2, 4'hF);
    wr(O_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [15:0] a, b;
    logic        sgn, ok;
    for (int i = 0; i < 14; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      if (i == 0) begin a = 16'h8000; b = 16'h8000; end
      if (i == 1) begin a = 16'h7FFF; b = 16'hFFFF; end
      if (i == 2) begin a = 16'hFFFF; b = 16'h0001; end
`ifdef SEQ_MULT_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`else
      sgn = 1'b0;
`endif
      wr(O_OPA, {16'h0, a}, 4'hF);
      wr(O_OPB, {16'h0, b}, 4'hF);
      wr(O_CTRL, {29'h0, sgn, 2'b01}, 4'hF);
      wait_done(ok);
      rd(O_RLO, v);
      tests++; if (v !== ref_lo(a, b, sgn)) begin fails++; $display("FAIL rand%0d_res_lo a=%h b=%h s=%b got %h want %h", i, a, b, sgn, v, ref_lo(a, b, sgn)); end
      rd(O_RHI, v);
      tests++; if (v !== 32'h0) begin fails++; $display("FAIL rand%0d_res_hi got %h want 0", i, v); end
      wr(O_STAT, 32'h2, 4'hF);
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_byte_mask();
    test_ack_pattern();
    test_unmapped();
    test_overrun();
    test_zero_operand();
    test_irq();
    test_reset_midrun();
    test_signed();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
